ex_muldiv: RTL and testbench

- Execute-stage HI/LO unit; consumes the decoded 6-bit funct produced in ID for SPECIAL-class instructions.
- Owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Raises a pipeline stall request while an iterative divide is in flight.
- Its result is muxed into the EX writeback value alongside the ALU result.

---
 rtl/ex_muldiv_if.sv | 34 +++
 rtl/ex_muldiv.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_if
//   Execute-stage bundle between the pipeline and the HI/LO multiply/divide
//   unit.
//
//   Pipeline -> unit : valid, flush, funct, operand_1 (rs), operand_2 (rt)
//   Unit -> pipeline : stall_req, result (MFHI/MFLO data), hi_out, lo_out
//
//   master modport : pipeline side (drives the instruction)
//   slave modport  : ex_muldiv side
// ---------------------------------------------------------------------------
interface ex_muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  flush;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic                  stall_req;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output valid, flush, funct, operand_1, operand_2,
        input  stall_req, result, hi_out, lo_out
    );

    modport slave (
        input  valid, flush, funct, operand_1, operand_2,
        output stall_req, result, hi_out, lo_out
    );
endinterface

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
//   Execute-stage HI/LO unit. Owns the architectural HI/LO registers and
//   executes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the decoded funct.
//
//   Ports:
//     clk  - pipeline clock
//     rst  - asynchronous, active-high reset
//     bus  - ex_muldiv_if.slave:
//              valid/flush/funct/operand_1/operand_2 in,
//              stall_req (hold IF/ID/EX), result (MFHI/MFLO data, else 0),
//              hi_out/lo_out (current HI/LO) out
//
//   Divide: restoring, one quotient bit per cycle on operand magnitudes,
//   signs applied in a final DONE cycle. stall_req is high for 33 cycles
//   (issue + 32 iterations). Divide by zero completes in the issue cycle
//   with LO=all-ones, HI=dividend. DIV_ITERS must equal DATA_WIDTH.
//
//   Build option MULDIV_MULT_PIPE_EN:
//     undefined - single-cycle multiply, no stall.
//     defined   - product registered in the issue cycle (1 stall cycle),
//                 {HI,LO} written at the end of the following cycle unless
//                 that cycle is flushed.
// ---------------------------------------------------------------------------
module ex_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_ITERS  = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    localparam int                    CNT_W    = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIV_ITERS - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(32'd1);
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONES_W   = {DATA_WIDTH{1'b1}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // Two's-complement negate of a data word.
    function automatic logic [DATA_WIDTH-1:0] negate_f(input logic [DATA_WIDTH-1:0] v);
        negate_f = ZERO_W - v;
    endfunction

    // Decode / operand preparation
    logic                    act_s;
    logic                    is_div_s;
    logic                    signed_div_s;
    logic                    div_zero_s;
    logic                    dvd_neg_s;
    logic                    dvs_neg_s;
    logic [DATA_WIDTH-1:0]   dvd_mag_s;
    logic [DATA_WIDTH-1:0]   dvs_mag_s;
    logic [2*DATA_WIDTH-1:0] mul_a_s;
    logic [2*DATA_WIDTH-1:0] mul_b_s;
    logic [2*DATA_WIDTH-1:0] prod_s;

    // Divider datapath
    logic [1:0]              state_r;
    logic [1:0]              state_nxt_s;
    logic [CNT_W-1:0]        counter_r;
    logic [CNT_W-1:0]        counter_nxt_s;
    logic [DATA_WIDTH-1:0]   rem_r;
    logic [DATA_WIDTH-1:0]   rem_nxt_s;
    logic [DATA_WIDTH-1:0]   quo_r;
    logic [DATA_WIDTH-1:0]   quo_nxt_s;
    logic [DATA_WIDTH-1:0]   dvs_r;
    logic [DATA_WIDTH-1:0]   dvs_nxt_s;
    logic                    q_neg_r;
    logic                    q_neg_nxt_s;
    logic                    r_neg_r;
    logic                    r_neg_nxt_s;
    logic [DATA_WIDTH:0]     partial_s;
    logic [DATA_WIDTH:0]     diff_s;
    logic [DATA_WIDTH-1:0]   quo_fix_s;
    logic [DATA_WIDTH-1:0]   rem_fix_s;
    logic                    div_stall_s;

    // Architectural state and outputs
    logic [DATA_WIDTH-1:0]   hi_r;
    logic [DATA_WIDTH-1:0]   lo_r;
    logic [DATA_WIDTH-1:0]   hi_nxt_s;
    logic [DATA_WIDTH-1:0]   lo_nxt_s;
    logic [DATA_WIDTH-1:0]   result_s;
    logic                    mul_stall_s;
    logic                    mul_busy_s;

    assign act_s        = bus.valid & ~bus.flush;
    assign is_div_s     = (bus.funct == FN_DIV) || (bus.funct == FN_DIVU);
    assign signed_div_s = (bus.funct == FN_DIV);
    assign div_zero_s   = (bus.operand_2 == ZERO_W);

    // Magnitudes and result signs for the divider (remainder follows dividend).
    always_comb begin
        dvd_neg_s = signed_div_s & bus.operand_1[DATA_WIDTH-1];
        dvs_neg_s = signed_div_s & bus.operand_2[DATA_WIDTH-1];
        dvd_mag_s = dvd_neg_s ? negate_f(bus.operand_1) : bus.operand_1;
        dvs_mag_s = dvs_neg_s ? negate_f(bus.operand_2) : bus.operand_2;
    end

    // Full-width product: sign- or zero-extend both operands, keep the low 2W bits.
    always_comb begin
        if (bus.funct == FN_MULT) begin
            mul_a_s = {{DATA_WIDTH{bus.operand_1[DATA_WIDTH-1]}}, bus.operand_1};
            mul_b_s = {{DATA_WIDTH{bus.operand_2[DATA_WIDTH-1]}}, bus.operand_2};
        end else begin
            mul_a_s = {ZERO_W, bus.operand_1};
            mul_b_s = {ZERO_W, bus.operand_2};
        end
        prod_s = mul_a_s * mul_b_s;
    end

`ifdef MULDIV_MULT_PIPE_EN
    logic                    is_mul_s;
    logic                    mul_pend_r;
    logic [2*DATA_WIDTH-1:0] mul_prod_r;

    assign is_mul_s    = (bus.funct == FN_MULT) || (bus.funct == FN_MULTU);
    assign mul_busy_s  = mul_pend_r;
    // The issue cycle stalls once; the held instruction is not re-issued in cycle two.
    assign mul_stall_s = (state_r == ST_IDLE) & act_s & is_mul_s & ~mul_pend_r;

    // Multiply first stage: capture the product in the issue cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_pend_r <= 1'b0;
            mul_prod_r <= {2*DATA_WIDTH{1'b0}};
        end else if (mul_pend_r) begin
            mul_pend_r <= 1'b0;
            mul_prod_r <= mul_prod_r;
        end else if (mul_stall_s) begin
            mul_pend_r <= 1'b1;
            mul_prod_r <= prod_s;
        end else begin
            mul_pend_r <= 1'b0;
            mul_prod_r <= mul_prod_r;
        end
    end
`else
    assign mul_busy_s  = 1'b0;
    assign mul_stall_s = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign partial_s = {rem_r, quo_r[DATA_WIDTH-1]};
    assign diff_s    = partial_s - {1'b0, dvs_r};

    // Final sign correction of the unsigned quotient/remainder.
    assign quo_fix_s = q_neg_r ? negate_f(quo_r) : quo_r;
    assign rem_fix_s = r_neg_r ? negate_f(rem_r) : rem_r;

    // Divider FSM next state, datapath and stall request.
    always_comb begin
        state_nxt_s   = state_r;
        counter_nxt_s = counter_r;
        rem_nxt_s     = rem_r;
        quo_nxt_s     = quo_r;
        dvs_nxt_s     = dvs_r;
        q_neg_nxt_s   = q_neg_r;
        r_neg_nxt_s   = r_neg_r;
        div_stall_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (act_s && is_div_s && !div_zero_s && !mul_busy_s) begin
                    state_nxt_s   = ST_BUSY;
                    counter_nxt_s = CNT_ZERO;
                    rem_nxt_s     = ZERO_W;
                    quo_nxt_s     = dvd_mag_s;
                    dvs_nxt_s     = dvs_mag_s;
                    q_neg_nxt_s   = dvd_neg_s ^ dvs_neg_s;
                    r_neg_nxt_s   = dvd_neg_s;
                    div_stall_s   = 1'b1;
                end else begin
                    state_nxt_s   = ST_IDLE;
                    div_stall_s   = 1'b0;
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    state_nxt_s   = ST_IDLE;
                    counter_nxt_s = CNT_ZERO;
                    div_stall_s   = 1'b0;
                end else begin
                    div_stall_s   = 1'b1;
                    counter_nxt_s = counter_r + CNT_ONE;
                    // A clear top bit means the divisor fit into the partial remainder.
                    if (!diff_s[DATA_WIDTH]) begin
                        rem_nxt_s = diff_s[DATA_WIDTH-1:0];
                        quo_nxt_s = {quo_r[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_nxt_s = partial_s[DATA_WIDTH-1:0];
                        quo_nxt_s = {quo_r[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (counter_r == CNT_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
            end
            ST_DONE: begin
                // Results are written this cycle; stall drops so the instruction retires.
                state_nxt_s   = ST_IDLE;
                counter_nxt_s = CNT_ZERO;
                div_stall_s   = 1'b0;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                counter_nxt_s = CNT_ZERO;
                div_stall_s   = 1'b0;
            end
        endcase
    end

    // HI/LO next value from the instruction in EX or the finishing divide.
    always_comb begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (mul_busy_s) begin
`ifdef MULDIV_MULT_PIPE_EN
                    if (!bus.flush) begin
                        {hi_nxt_s, lo_nxt_s} = mul_prod_r;
                    end else begin
                        hi_nxt_s = hi_r;
                        lo_nxt_s = lo_r;
                    end
`else
                    hi_nxt_s = hi_r;
                    lo_nxt_s = lo_r;
`endif
                end else if (act_s) begin
                    case (bus.funct)
                        FN_MTHI: hi_nxt_s = bus.operand_1;
                        FN_MTLO: lo_nxt_s = bus.operand_1;
`ifndef MULDIV_MULT_PIPE_EN
                        FN_MULT, FN_MULTU: {hi_nxt_s, lo_nxt_s} = prod_s;
`endif
                        FN_DIV, FN_DIVU: begin
                            if (div_zero_s) begin
                                lo_nxt_s = ONES_W;
                                hi_nxt_s = bus.operand_1;
                            end else begin
                                hi_nxt_s = hi_r;
                                lo_nxt_s = lo_r;
                            end
                        end
                        default: begin
                            hi_nxt_s = hi_r;
                            lo_nxt_s = lo_r;
                        end
                    endcase
                end else begin
                    hi_nxt_s = hi_r;
                    lo_nxt_s = lo_r;
                end
            end
            ST_DONE: begin
                if (!bus.flush) begin
                    lo_nxt_s = quo_fix_s;
                    hi_nxt_s = rem_fix_s;
                end else begin
                    hi_nxt_s = hi_r;
                    lo_nxt_s = lo_r;
                end
            end
            default: begin
                hi_nxt_s = hi_r;
                lo_nxt_s = lo_r;
            end
        endcase
    end

    // MFHI/MFLO read path; zero while in reset and for all other functs.
    always_comb begin
        result_s = ZERO_W;
        if (!rst && act_s) begin
            case (bus.funct)
                FN_MFHI: result_s = hi_r;
                FN_MFLO: result_s = lo_r;
                default: result_s = ZERO_W;
            endcase
        end else begin
            result_s = ZERO_W;
        end
    end

    // Divider state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            counter_r <= CNT_ZERO;
            rem_r     <= ZERO_W;
            quo_r     <= ZERO_W;
            dvs_r     <= ZERO_W;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            counter_r <= counter_nxt_s;
            rem_r     <= rem_nxt_s;
            quo_r     <= quo_nxt_s;
            dvs_r     <= dvs_nxt_s;
            q_neg_r   <= q_neg_nxt_s;
            r_neg_r   <= r_neg_nxt_s;
        end
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= ZERO_W;
            lo_r <= ZERO_W;
        end else begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end
    end

    // Stall must act in the same cycle, so it is combinational; reset forces it low.
    assign bus.stall_req = (div_stall_s | mul_stall_s) & ~rst;
    assign bus.result    = result_s;
    assign bus.hi_out    = hi_r;
    assign bus.lo_out    = lo_r;
endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv
//   Self-checking bench for ex_muldiv: a table of instruction vectors with
//   expected HI/LO and stall length, a few model-checked random divides, and
//   hand-written flush/reset/back-to-back sequences. Expected results are
//   queued when an instruction is driven and compared when it retires.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;
    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULDIV_MULT_PIPE_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 0;
`endif
    localparam int DIV_STALL = 33;
    localparam int STALL_CAP = 100;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_muldiv_if #(.DATA_WIDTH(W)) bus ();

    ex_muldiv #(.DATA_WIDTH(W), .DIV_ITERS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[13];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.valid     = 1'b1;
        bus.flush     = 1'b0;
        bus.funct     = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
    endtask

    task automatic idle();
        bus.valid     = 1'b0;
        bus.flush     = 1'b0;
        bus.funct     = 6'h00;
        bus.operand_1 = 32'd0;
        bus.operand_2 = 32'd0;
    endtask

    // Issue one instruction, count stall cycles, compare HI/LO after it retires.
    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input int stalls);
        exp_t e;
        int   n;
        e.name   = name;
        e.hi     = hi;
        e.lo     = lo;
        e.stalls = stalls;
        sb_q.push_back(e);
        drive(f, a, b);
        #1;
        n = 0;
        while (bus.stall_req && n < STALL_CAP) begin
            n++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        e = sb_q.pop_front();
        check32({e.name, " stall cycles"}, 32'(n), 32'(e.stalls));
        check32({e.name, " HI"}, bus.hi_out, e.hi);
        check32({e.name, " LO"}, bus.lo_out, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    // Issue MFHI/MFLO and compare the same-cycle result.
    task automatic read_chk(input string name, input logic [5:0] f, input logic [31:0] exp);
        drive(f, 32'd0, 32'd0);
        #1;
        check32({name, " result"}, bus.result, exp);
        check32({name, " stall"}, {31'd0, bus.stall_req}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rhi;
        logic [31:0] rlo;
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        int          n;

        vecs[0]  = '{F_MULT,  32'hFFFFFFFD, 32'd5,       32'hFFFFFFFF, 32'hFFFFFFF1, MUL_STALL};
        vecs[1]  = '{F_MULTU, 32'hFFFFFFFD, 32'd5,       32'h00000004, 32'hFFFFFFF1, MUL_STALL};
        vecs[2]  = '{F_DIVU,  32'd100,      32'd7,       32'd2,        32'd14,       DIV_STALL};
        vecs[3]  = '{F_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, DIV_STALL};
        vecs[4]  = '{F_DIV,   32'd7,        32'd0,       32'd7,        32'hFFFFFFFF, 0};
        vecs[5]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,       32'h80000000, DIV_STALL};
        vecs[6]  = '{F_MTHI,  32'h00001234, 32'd0,       32'h00001234, 32'h80000000, 0};
        vecs[7]  = '{F_MTLO,  32'h00005678, 32'd0,       32'h00001234, 32'h00005678, 0};
        vecs[8]  = '{F_MULT,  32'd6,        32'd7,       32'd0,        32'd42,       MUL_STALL};
        vecs[9]  = '{F_DIVU,  32'hFFFFFFFF, 32'd3,       32'd0,        32'h55555555, DIV_STALL};
        vecs[10] = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,       32'hFFFFFFFD, DIV_STALL};
        vecs[11] = '{F_DIVU,  32'd5,        32'd0,       32'd5,        32'hFFFFFFFF, 0};
        vecs[12] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_STALL};

        idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check32("reset HI", bus.hi_out, 32'd0);
        check32("reset LO", bus.lo_out, 32'd0);
        check32("reset stall", {31'd0, bus.stall_req}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        read_chk("reset MFHI", F_MFHI, 32'd0);
        read_chk("reset MFLO", F_MFLO, 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].stalls);
            read_chk($sformatf("vec%0d MFLO", i), F_MFLO, vecs[i].lo);
            read_chk($sformatf("vec%0d MFHI", i), F_MFHI, vecs[i].hi);
        end

        // Random divides against a reference built on SV division semantics.
        for (int i = 0; i < 6; i++) begin
            rf = (i % 2 == 0) ? F_DIV : F_DIVU;
            ra = $urandom;
            rb = 32'($urandom_range(1, 2000));
            if ($urandom_range(0, 1) == 1) rb = 32'd0 - rb;
            if (rf == F_DIVU) begin
                rlo = ra / rb;
                rhi = ra % rb;
            end else begin
                sa  = longint'($signed(ra));
                sb  = longint'($signed(rb));
                sq  = sa / sb;
                sr  = sa % sb;
                rlo = sq[31:0];
                rhi = sr[31:0];
            end
            run_op($sformatf("rand%0d", i), rf, ra, rb, rhi, rlo, DIV_STALL);
        end

        // Flush at T10 of a divide: stall drops at once, HI/LO untouched.
        run_op("mthi", F_MTHI, 32'h00001234, 32'd0, 32'h00001234, m_lo, 0);
        drive(F_DIVU, 32'd100, 32'd7);
        #1;
        check32("flushT10 issue stall", {31'd0, bus.stall_req}, 32'd1);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check32("flushT10 stall", {31'd0, bus.stall_req}, 32'd0);
        @(negedge clk);
        idle();
        repeat (40) @(negedge clk);
        check32("flushT10 HI", bus.hi_out, 32'h00001234);
        check32("flushT10 LO", bus.lo_out, m_lo);
        read_chk("flushT10 MFHI", F_MFHI, 32'h00001234);

        // Flush in the DONE cycle cancels the write.
        drive(F_DIVU, 32'd100, 32'd7);
        #1;
        n = 0;
        while (bus.stall_req && n < STALL_CAP) begin
            n++;
            @(negedge clk);
            #1;
        end
        check32("flushDONE stall cycles", 32'(n), 32'(DIV_STALL));
        bus.flush = 1'b1;
        @(negedge clk);
        idle();
        @(negedge clk);
        check32("flushDONE HI", bus.hi_out, 32'h00001234);
        check32("flushDONE LO", bus.lo_out, m_lo);

        // Back-to-back divides, each with a full stall.
        run_op("b2b first", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_STALL);
        run_op("b2b second", F_DIVU, 32'd50, 32'd6, 32'd2, 32'd8, DIV_STALL);
        idle();
        @(negedge clk);

`ifdef MULDIV_MULT_PIPE_EN
        // Flush in the second multiply cycle cancels the write.
        drive(F_MULT, 32'd3, 32'd3);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        idle();
        @(negedge clk);
        check32("mulflush HI", bus.hi_out, m_hi);
        check32("mulflush LO", bus.lo_out, m_lo);
`endif

        // Reset at T20 of a divide: immediate clear and no stall.
        drive(F_DIVU, 32'd1000, 32'd3);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check32("rstT20 stall", {31'd0, bus.stall_req}, 32'd0);
        check32("rstT20 HI", bus.hi_out, 32'd0);
        check32("rstT20 LO", bus.lo_out, 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        repeat (40) @(negedge clk);
        read_chk("rstT20 MFHI", F_MFHI, 32'd0);
        read_chk("rstT20 MFLO", F_MFLO, 32'd0);
        idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
